// File: rtl/bit_tx_pkg.sv
// Shared definitions for the bit transmitter control path: FSM state encoding
// and default field widths.
package bit_tx_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PORT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PORT  = 3'd1,
    COUNT = 3'd2,
    LOAD  = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register, MSB first (new bit enters at bit 0).
// Synchronous active-low clear has priority over the shift enable.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  genvar gi;

  assign q_next[0] = din;

  generate
    for (gi = 1; gi < W; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/bit_frame_controller.sv
// Parses start bit, port address and bit-count field from serIn and drives the
// transmitter's load / enable / count inputs plus a one-hot sink select.
module bit_frame_controller
  import bit_tx_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PORT_W = DEF_PORT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serIn,
  input  logic                   cout,
  output logic                   load,
  output logic                   cnt_8_en,
  output logic [CNT_W-1:0]       parin_8_cnt,
  output logic [(2**PORT_W)-1:0] port_sel,
  output logic                   busy,
  output logic                   done
);

  localparam int NSEL      = 2 ** PORT_W;
  localparam int FIELD_MAX = (CNT_W > PORT_W) ? CNT_W : PORT_W;
  localparam int BC_W      = $clog2(FIELD_MAX) + 1;

  localparam logic [BC_W-1:0] PORT_LAST = BC_W'(PORT_W - 1);
  localparam logic [BC_W-1:0] CNT_LAST  = BC_W'(CNT_W - 1);

  state_t state_reg, state_next;
  logic [BC_W-1:0] bit_cnt_reg, bit_cnt_next;

  logic port_shift_en;
  logic count_shift_en;
  logic [PORT_W-1:0] port_q;
  logic [CNT_W-2:0]  count_hi_q;
  logic [CNT_W-1:0]  count_full;
  logic [NSEL-1:0]   port_onehot;

  logic                 load_reg, load_next;
  logic                 cnt_en_reg, cnt_en_next;
  logic [CNT_W-1:0]     parin_reg, parin_next;
  logic [NSEL-1:0]      port_sel_reg, port_sel_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  genvar gi;

  sipo_shift #(.W(PORT_W)) u_port_shift (
    .clk   (clk),
    .clr_n (rst),
    .en    (port_shift_en),
    .din   (serIn),
    .q     (port_q)
  );

  // Only the first CNT_W-1 count bits are stored; the last one is taken straight
  // from serIn so the full count is available on the edge that enters LOAD.
  sipo_shift #(.W(CNT_W - 1)) u_count_shift (
    .clk   (clk),
    .clr_n (rst),
    .en    (count_shift_en),
    .din   (serIn),
    .q     (count_hi_q)
  );

  assign count_full = {count_hi_q, serIn};

  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_onehot
      assign port_onehot[gi] = (port_q == PORT_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    port_shift_en  = 1'b0;
    count_shift_en = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!serIn) begin
          state_next   = PORT;
          bit_cnt_next = '0;
        end
      end
      PORT: begin
        port_shift_en = 1'b1;
        if (bit_cnt_reg == PORT_LAST) begin
          state_next   = COUNT;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
        end
      end
      COUNT: begin
        count_shift_en = 1'b1;
        if (bit_cnt_reg == CNT_LAST) begin
          state_next   = (count_full == '0) ? DONE : LOAD;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
        end
      end
      LOAD: state_next = DATA;
      DATA: begin
        if (cout) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one leaves a flop.
  always_comb begin
    load_next     = (state_next == LOAD);
    cnt_en_next   = (state_next == DATA);
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    port_sel_next = (state_next == DATA) ? port_onehot : '0;
    parin_next    = (state_next == LOAD) ? count_full : parin_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      load_reg     <= 1'b0;
      cnt_en_reg   <= 1'b0;
      parin_reg    <= '0;
      port_sel_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      load_reg     <= load_next;
      cnt_en_reg   <= cnt_en_next;
      parin_reg    <= parin_next;
      port_sel_reg <= port_sel_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign load        = load_reg;
  assign cnt_8_en    = cnt_en_reg;
  assign parin_8_cnt = parin_reg;
  assign port_sel    = port_sel_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_bit_frame_controller.sv
// Self-checking bench for bit_frame_controller: per-frame expected output traces
// are built from the frame rules and compared cycle by cycle.
module tb_bit_frame_controller;

  localparam int CNT_W  = 8;
  localparam int PORT_W = 2;

  typedef struct packed {
    logic       load;
    logic       en;
    logic [7:0] parin;
    logic [3:0] psel;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serIn = 1'b1;
  logic       cout = 1'b0;
  logic       load;
  logic       cnt_8_en;
  logic [7:0] parin_8_cnt;
  logic [3:0] port_sel;
  logic       busy;
  logic       done;

  obs_t       obs_q[$];
  obs_t       exp_q[$];
  logic [7:0] exp_parin;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  bit_frame_controller #(.CNT_W(CNT_W), .PORT_W(PORT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .serIn       (serIn),
    .cout        (cout),
    .load        (load),
    .cnt_8_en    (cnt_8_en),
    .parin_8_cnt (parin_8_cnt),
    .port_sel    (port_sel),
    .busy        (busy),
    .done        (done)
  );

  function automatic obs_t mk(input logic l, input logic e, input logic [7:0] p,
                              input logic [3:0] s, input logic b, input logic d);
    obs_t o;
    o.load = l; o.en = e; o.parin = p; o.psel = s; o.busy = b; o.done = d;
    return o;
  endfunction

  // One clock: drive inputs, let the edge happen, record outputs on the falling edge.
  task automatic tick(input logic sin, input logic c);
    serIn = sin;
    cout  = c;
    @(posedge clk);
    @(negedge clk);
    obs_q.push_back(mk(load, cnt_8_en, parin_8_cnt, port_sel, busy, done));
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Drives one whole frame; the transmitter raises cout on the n-th enable cycle.
  task automatic drive_frame(input logic [1:0] port, input logic [7:0] count,
                             input int n, input bit spur, input logic next_sin);
    tick(1'b0, spur ? rbit() : 1'b0);
    for (int b = PORT_W - 1; b >= 0; b--) tick(port[b], spur ? rbit() : 1'b0);
    for (int b = CNT_W - 1; b >= 0; b--) tick(count[b], spur ? rbit() : 1'b0);
    if (count != 8'd0) begin
      tick(rbit(), spur ? rbit() : 1'b0);
      for (int j = 1; j <= n; j++) tick(rbit(), (j == n) ? 1'b1 : 1'b0);
    end
    tick(next_sin, spur ? rbit() : 1'b0);
  endtask

  // Expected trace of a frame: header bits busy, optional load + n data cycles,
  // one done cycle, then idle.
  task automatic model_frame(input logic [1:0] port, input logic [7:0] count, input int n);
    for (int i = 0; i < PORT_W + CNT_W; i++) exp_q.push_back(mk(0, 0, exp_parin, 4'd0, 1, 0));
    if (count != 8'd0) begin
      exp_parin = count;
      exp_q.push_back(mk(1, 0, exp_parin, 4'd0, 1, 0));
      for (int j = 0; j < n; j++) exp_q.push_back(mk(0, 1, exp_parin, 4'd1 << port, 1, 0));
    end
    exp_q.push_back(mk(0, 0, exp_parin, 4'd0, 1, 1));
    exp_q.push_back(mk(0, 0, exp_parin, 4'd0, 0, 0));
  endtask

  task automatic test_reset();
    obs_q.delete(); exp_q.delete();
    rst = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    exp_parin = 8'd0;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 8'd0, 4'd0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL reset cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    int loads, ens, dones;
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b10, 8'h03, 3, 0, 1'b1);
    model_frame(2'b10, 8'h03, 3);
    loads = 0; ens = 0; dones = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL nominal cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    foreach (obs_q[i]) begin
      loads += int'(obs_q[i].load);
      ens   += int'(obs_q[i].en);
      dones += int'(obs_q[i].done);
    end
    n_checks++;
    if (loads != 1) $display("FAIL nominal_load_cycles: got %0d required 1", loads);
    else n_pass++;
    n_checks++;
    if (ens != 3) $display("FAIL nominal_en_cycles: got %0d required 3", ens);
    else n_pass++;
    n_checks++;
    if (dones != 1) $display("FAIL nominal_done_cycles: got %0d required 1", dones);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    int ens;
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b01, 8'h00, 0, 0, 1'b1);
    model_frame(2'b01, 8'h00, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL zero_count cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    ens = 0;
    foreach (obs_q[i]) ens += int'(obs_q[i].en) + int'(obs_q[i].load) + int'(obs_q[i].psel != 4'd0);
    n_checks++;
    if (ens != 0) $display("FAIL zero_count_no_activity: got %0d active cycles required 0", ens);
    else n_pass++;
  endtask

  task automatic test_max_count();
    int ens;
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b11, 8'hFF, 255, 0, 1'b1);
    model_frame(2'b11, 8'hFF, 255);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL max_count cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    ens = 0;
    foreach (obs_q[i]) ens += int'(obs_q[i].en);
    n_checks++;
    if (ens != 255) $display("FAIL max_count_en_cycles: got %0d required 255", ens);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b00, 8'h04, 4, 0, 1'b0);
    drive_frame(2'b11, 8'h09, 9, 0, 1'b1);
    model_frame(2'b00, 8'h04, 4);
    model_frame(2'b11, 8'h09, 9);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL back_to_back cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_spurious_cout();
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b10, 8'h06, 6, 1, 1'b1);
    model_frame(2'b10, 8'h06, 6);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL spurious_cout cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_q.delete(); exp_q.delete();
    drive_frame(2'b01, 8'h05, 5, 0, 1'b1);
    model_frame(2'b01, 8'h05, 5);
    // Abort after three count bits of the next frame.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b1); tick(1'b1, 1'b0);
    for (int i = 0; i < 1 + PORT_W + 3; i++) exp_q.push_back(mk(0, 0, exp_parin, 4'd0, 1, 0));
    rst = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    rst = 1'b1;
    exp_parin = 8'd0;
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(0, 0, 8'd0, 4'd0, 0, 0));
    tick(1'b1, 1'b0);
    exp_q.push_back(mk(0, 0, 8'd0, 4'd0, 0, 0));
    drive_frame(2'b10, 8'h02, 2, 0, 1'b1);
    model_frame(2'b10, 8'h02, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL reset_mid_frame cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_frames();
    logic [1:0] port;
    logic [7:0] count;
    int         gap;
    obs_q.delete(); exp_q.delete();
    for (int f = 0; f < 8; f++) begin
      port  = 2'($urandom_range(0, 3));
      count = 8'($urandom_range(0, 15));
      gap   = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick(1'b1, rbit());
        exp_q.push_back(mk(0, 0, exp_parin, 4'd0, 0, 0));
      end
      drive_frame(port, count, int'(count), 1, rbit());
      model_frame(port, count, int'(count));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL random cyc %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    exp_parin = 8'd0;
    test_reset();
    test_nominal();
    test_zero_count();
    test_max_count();
    test_back_to_back();
    test_spurious_cout();
    test_reset_mid_frame();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
